// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - framed valid/ready CRC engine, one DATA_W beat folded per clock
`timescale 1ns/1ps
module crc_stream_engine #(
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(16'hFFFF),
  parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(16'h0000),
  parameter int unsigned      CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  beat_count,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t            state;
  logic [CRC_W-1:0]  crc_reg;
  logic [CRC_W-1:0]  crc_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic              beat_acc;

  // Whole beat folded MSB-first in one cycle; the loop unrolls into an XOR tree.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c_in,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  always_comb begin
    crc_next = crc_step(crc_reg, in_data);
    cnt_inc  = (beat_count == {CNT_W{1'b1}}) ? beat_count : beat_count + CNT_W'(1);
    in_ready = (state == S_ACCUM) && !start;
    beat_acc = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      crc_reg    <= INIT;
      crc_out    <= '0;
      crc_valid  <= 1'b0;
      beat_count <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            crc_reg    <= INIT;
            beat_count <= '0;
            state      <= S_ACCUM;
            busy       <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (start) begin
            crc_reg    <= INIT;
            beat_count <= '0;
          end else if (beat_acc) begin
            crc_reg    <= crc_next;
            beat_count <= cnt_inc;
            if (in_last) begin
              crc_out   <= crc_next ^ XOR_OUT;
              crc_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // A start that arrives before the result is taken is dropped so the result survives.
          if (crc_valid && out_ready) begin
            crc_valid <= 1'b0;
            if (start) begin
              crc_reg    <= INIT;
              beat_count <= '0;
              state      <= S_ACCUM;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - frame-level model bench for crc_stream_engine (CRC-16 and CRC-8 instances)
`timescale 1ns/1ps
module tb_crc_stream_engine;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, crc_valid, busy;
  logic [15:0] crc_out, beat_count;
  logic        in_ready8, crc_valid8, busy8;
  logic [7:0]  crc_out8;
  logic [15:0] beat_count8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  crc_stream_engine dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .crc_out(crc_out), .crc_valid(crc_valid),
    .out_ready(out_ready), .beat_count(beat_count), .busy(busy)
  );

  crc_stream_engine #(.DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready8), .crc_out(crc_out8), .crc_valid(crc_valid8),
    .out_ready(out_ready), .beat_count(beat_count8), .busy(busy8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC over a whole message, straight polynomial division bit by bit.
  function automatic logic [31:0] crc_ref(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input byte_q_t msg);
    logic [31:0] mask;
    logic [31:0] r;
    logic        top;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    r = init & mask;
    foreach (msg[k]) begin
      for (int b = 7; b >= 0; b--) begin
        top = r[w-1] ^ msg[k][b];
        r = (r << 1) & mask;
        if (top) r = r ^ poly;
      end
    end
    return r;
  endfunction

  // Frame-level model: phase 0 idle, 1 collecting, 2 holding result.
  int          phase = 0;
  byte_q_t     frame;
  logic        m_valid = 1'b0;
  logic [15:0] m_out16 = 16'h0;
  logic [7:0]  m_out8 = 8'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      frame.delete();
      m_valid = 1'b0;
      m_out16 = 16'h0;
      m_out8 = 8'h0;
    end else begin
      case (phase)
        0: if (start) begin phase = 1; frame.delete(); end
        1: begin
          if (start) frame.delete();
          else if (in_valid) begin
            frame.push_back(in_data);
            if (in_last) begin
              phase = 2;
              m_valid = 1'b1;
              m_out16 = crc_ref(16, 32'h1021, 32'hFFFF, frame) ^ 16'h0000;
              m_out8 = 8'(crc_ref(8, 32'h07, 32'h00, frame));
            end
          end
        end
        default: if (out_ready) begin
          m_valid = 1'b0;
          if (start) begin phase = 1; frame.delete(); end
          else phase = 0;
        end
      endcase
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(phase == 1 && !start));
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("crc_valid", 32'(crc_valid), 32'(m_valid));
      chk("crc_out", 32'(crc_out), 32'(m_out16));
      chk("beat_count", 32'(beat_count), 32'(frame.size()));
      chk("in_ready8", 32'(in_ready8), 32'(phase == 1 && !start));
      chk("busy8", 32'(busy8), 32'(phase != 0));
      chk("crc_valid8", 32'(crc_valid8), 32'(m_valid));
      chk("crc_out8", 32'(crc_out8), 32'(m_out8));
      chk("beat_count8", 32'(beat_count8), 32'(frame.size()));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input byte_q_t msg, input bit gaps, input bit has_last);
    for (int k = 0; k < msg.size(); k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = msg[k];
      in_last = has_last && (k == msg.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (crc_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (crc_valid !== 1'b1) chk("timeout_crc_valid", 32'(crc_valid), 32'h1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [15:0] exp16, input logic [7:0] exp8,
                              input int exp_cnt);
    chk({tag, "_crc16"}, 32'(crc_out), 32'(exp16));
    chk({tag, "_crc8"}, 32'(crc_out8), 32'(exp8));
    chk({tag, "_count"}, 32'(beat_count), 32'(exp_cnt));
    chk({tag, "_valid"}, 32'(crc_valid), 32'h1);
  endtask

  initial begin
    byte_q_t msg9;
    byte_q_t pre;
    logic [15:0] held16;
    logic [7:0]  held8;
    msg9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    pre = '{8'h31, 8'h32, 8'h33, 8'h34};

    chk("model_ccitt_pin", crc_ref(16, 32'h1021, 32'hFFFF, msg9), 32'h29B1);
    chk("model_crc8_pin", crc_ref(8, 32'h07, 32'h00, msg9), 32'hF4);

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(crc_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_count", 32'(beat_count), 32'h0);
    chk("rst_crc_out", 32'(crc_out), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, then result held while the consumer stalls.
    pulse_start();
    send(msg9, 1'b0, 1'b1);
    wait_valid();
    check_result("basic", 16'h29B1, 8'hF4, 9);
    held16 = crc_out;
    held8 = crc_out8;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(negedge clk);
      chk("hold_valid", 32'(crc_valid8), 32'h1);
      chk("hold_crc16", 32'(crc_out), 32'(held16));
      chk("hold_crc8", 32'(crc_out8), 32'(held8));
    end
    start = 1'b0;
    ack();
    chk("idle_after_ack", 32'(busy), 32'h0);

    // Bubbles on the input stream.
    pulse_start();
    send(msg9, 1'b1, 1'b1);
    wait_valid();
    check_result("gaps", 16'h29B1, 8'hF4, 9);
    ack();

    // Restart mid-frame; the start cycle must refuse the beat offered with it.
    pulse_start();
    send('{8'h31, 8'h32}, 1'b0, 1'b0);
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h33;
    #1;
    chk("restart_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    send(msg9, 1'b0, 1'b1);
    wait_valid();
    check_result("restart", 16'h29B1, 8'hF4, 9);

    // Back-to-back: ack and start together, no IDLE bubble.
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'h1);
    chk("b2b_valid_clear", 32'(crc_valid), 32'h0);
    send(msg9, 1'b0, 1'b1);
    wait_valid();
    check_result("b2b", 16'h29B1, 8'hF4, 9);
    ack();

    // Asynchronous reset mid-frame.
    pulse_start();
    send(pre, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(beat_count), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'h0);
    chk("async_rst_count", 32'(beat_count), 32'h0);
    chk("async_rst_crc_out", 32'(crc_out), 32'h0);
    chk("async_rst_valid", 32'(crc_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    send(msg9, 1'b0, 1'b1);
    wait_valid();
    check_result("post_reset", 16'h29B1, 8'hF4, 9);
    ack();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised successor to the team's single-bit XOR gate: an XOR-tree CRC engine that folds a DATA_W-bit stream into a CRC_W-bit remainder, one beat per clock.
- Valid/ready input stream, framed by start and in_last.
- Result held on a valid/ready output.
- Sits between packet sources and link/storage checkers; any polynomial is selected by parameter.

Parameters:
- DATA_W, 8, input beat width in bits (>=1); processed MSB-first, fully unrolled per cycle.
- CRC_W, 16, CRC register width (1..32).
- POLY, 16'h1021, generator polynomial, implicit x^CRC_W term omitted.
- INIT, 16'hFFFF, CRC register value loaded at frame start.
- XOR_OUT, 16'h0000, value XORed into the register to form crc_out.
- CNT_W, 16, width of the saturating beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame start strobe.
- in_valid  in  1  input beat valid.
- in_data  in  DATA_W  input beat.
- in_last  in  1  final beat of the frame; qualified by in_valid && in_ready.
- in_ready  out  1  engine accepts a beat this cycle.
- crc_out  out  CRC_W  final CRC, stable while crc_valid=1.
- crc_valid  out  1  crc_out valid.
- out_ready  in  1  consumer accepts crc_out.
- beat_count  out  CNT_W  accepted beats in the current or last frame; saturates at all-ones.
- busy  out  1  high in ACCUM and DONE.

Behaviour:
- Reset (async assert, sync release) sets:
  - state = IDLE, crc_reg = INIT, crc_out = 0, crc_valid = 0, beat_count = 0, busy = 0, in_ready = 0.
- Step function f(c, d): for i = DATA_W-1 down to 0:
  - fb = c[CRC_W-1] ^ d[i]
  - c = (c << 1) truncated to CRC_W
  - if fb, c ^= POLY
- States:
  - IDLE:
    - in_ready = 0.
    - start=1 -> crc_reg <= INIT, beat_count <= 0, next = ACCUM.
    - in_valid is ignored.
  - ACCUM:
    - in_ready = !start (combinational).
    - start=1 restarts the frame: crc_reg <= INIT, beat_count <= 0, stay in ACCUM. No beat is accepted that cycle.
    - Accepted beat (in_valid && in_ready): crc_reg <= f(crc_reg, in_data), beat_count <= beat_count+1, saturating.
    - Accepted beat with in_last=1: crc_out <= f(crc_reg, in_data) ^ XOR_OUT, crc_valid <= 1, next = DONE.
  - DONE:
    - in_ready = 0; crc_out and beat_count are held.
    - crc_valid && out_ready -> crc_valid <= 0.
      - If start=1 in the same cycle: crc_reg <= INIT, beat_count <= 0, next = ACCUM (back-to-back frames, no IDLE bubble).
      - Otherwise next = IDLE.
    - start without out_ready is ignored; the result must not be lost.
- Latency:
  - crc_valid rises the cycle after the last beat is accepted.
  - The minimum frame is start, 1 beat, result: 3 cycles.
- Throughput: one beat per cycle in ACCUM with in_valid held high.
- busy = (state != IDLE), registered from state.
- Zero-length frames are not supported. A frame ends only on an accepted in_last beat.
- Reset mid-frame discards everything, with the reset values above; no partial CRC is emitted.
- crc_out keeps its last value in IDLE. It is only meaningful while crc_valid=1.

Test Plan:
- Default params; start, then ASCII "123456789" (0x31..0x39) one beat/cycle, in_last on 0x39 -> crc_valid=1 one cycle after the last beat, crc_out=16'h29B1, beat_count=9.
- CRC_W=8, POLY=8'h07, INIT=8'h00, same 9 bytes -> crc_out=8'hF4. Then hold out_ready=0 for 5 cycles -> crc_valid and crc_out stay constant.
- Default params; "123456789" with in_valid deasserted on alternate cycles -> same 16'h29B1, beat_count=9, no beat lost or duplicated.
- Start frame, send 0x31 0x32, assert start again (in_ready must read 0 that cycle), then send "123456789" -> crc_out=16'h29B1, beat_count=9.
- Finish a frame; in DONE drive out_ready=1 and start=1 together, then send "123456789" -> no IDLE cycle, busy stays 1, second crc_out=16'h29B1.
- Mid-frame (after 4 beats) pulse rst_n low for 1 ns between edges -> all outputs return to reset values immediately. A fresh "123456789" frame then yields 16'h29B1.
